// File: rtl/bpm_pkg.sv
// Shared types and sizing helpers for the beat-to-tempo estimator.
package bpm_pkg;

  typedef enum logic [1:0] {IDLE, TRACK, DIVIDE} bpm_state_e;

  localparam int RING_DEPTH = 4;

  // Bits needed to hold the longest tracked beat interval, in clk cycles.
  function automatic int interval_w(longint clk_hz, longint min_bpm);
    return $clog2(longint'(60) * clk_hz / min_bpm + longint'(1));
  endfunction

  // Bits needed to hold 60*clk_hz, the cycles-per-minute dividend.
  function automatic int dividend_w(longint clk_hz);
    return $clog2(longint'(60) * clk_hz + longint'(1));
  endfunction

endpackage

// File: rtl/seq_divider.sv
// Restoring unsigned divider, one quotient bit per cycle; the first bit is resolved on the start edge,
// so done pulses W-1 cycles after start is sampled. abort drops any divide in flight.
module seq_divider #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         abort,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] quotient
);

  localparam int CW = $clog2(W + 1);

  logic [W-1:0]  rem_q, dvd_q, dsr_q, quo_q;
  logic [CW-1:0] cnt_q;
  logic          busy_q, done_q;

  logic [W-1:0]  rem_src, dvd_src, dsr_src, quo_src;
  logic [W-1:0]  rem_nxt, dvd_nxt, quo_nxt;
  logic [W:0]    trial;
  logic          take;

  // A start takes its operands straight from the ports so no cycle is spent loading.
  always_comb begin
    rem_src = start ? '0 : rem_q;
    dvd_src = start ? dividend : dvd_q;
    dsr_src = start ? divisor : dsr_q;
    quo_src = start ? '0 : quo_q;
    trial   = {rem_src, dvd_src[W-1]};
    take    = (trial >= {1'b0, dsr_src});
    rem_nxt = take ? W'(trial - {1'b0, dsr_src}) : trial[W-1:0];
    dvd_nxt = dvd_src << 1;
    quo_nxt = (quo_src << 1) | W'(take);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rem_q  <= '0;
      dvd_q  <= '0;
      dsr_q  <= '0;
      quo_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else if (abort) begin
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start) begin
        rem_q  <= rem_nxt;
        dvd_q  <= dvd_nxt;
        dsr_q  <= dsr_src;
        quo_q  <= quo_nxt;
        cnt_q  <= CW'(W - 1);
        busy_q <= (W > 1) ? 1'b1 : 1'b0;
        done_q <= (W > 1) ? 1'b0 : 1'b1;
      end else if (busy_q) begin
        rem_q <= rem_nxt;
        dvd_q <= dvd_nxt;
        quo_q <= quo_nxt;
        cnt_q <= cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign quotient = quo_q;

endmodule

// File: rtl/bpm_estimator.sv
// Beat-interval tracker: 4-deep interval average divided into cycles-per-minute gives BPM.
// Output lands 2+W+1 cycles after an accepted beat; silence of MAX_INTERVAL cycles drops back to IDLE.
module bpm_estimator
  import bpm_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int MAX_BPM     = 200,
  parameter int MIN_BPM     = 40
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         beat_pulse,
  output logic [$clog2(MAX_BPM+1)-1:0] BPM_estimate,
  output logic                         bpm_valid,
  output logic                         bpm_update
);

  localparam longint DIVIDEND     = longint'(60) * longint'(CLK_FREQ_HZ);
  localparam longint MIN_INTERVAL = DIVIDEND / longint'(MAX_BPM);
  localparam longint MAX_INTERVAL = DIVIDEND / longint'(MIN_BPM);
  localparam int     IW = interval_w(longint'(CLK_FREQ_HZ), longint'(MIN_BPM));
  localparam int     W  = dividend_w(longint'(CLK_FREQ_HZ));
  localparam int     SW = IW + 2;
  localparam int     BW = $clog2(MAX_BPM + 1);
  localparam int     PW = $clog2(RING_DEPTH);

  localparam logic [IW-1:0] MIN_IVL = IW'(MIN_INTERVAL);
  localparam logic [IW-1:0] MAX_IVL = IW'(MAX_INTERVAL);
  localparam logic [W-1:0]  DVD     = W'(DIVIDEND);
  localparam logic [W-1:0]  SAT_W   = W'(MAX_BPM);
  localparam logic [BW-1:0] SAT_B   = BW'(MAX_BPM);

  bpm_state_e    state_q, state_d;
  logic [IW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] ring_q [RING_DEPTH];
  logic [PW-1:0] wp_q;
  logic          filled_q;
  logic [SW-1:0] sum_q, sum_c;
  logic          wr1_q, wr2_q;
  logic          pend_q, pend_d;
  logic [BW-1:0] bpm_q;
  logic          valid_q, upd_q;

  logic          timeout, accept, div_start, out_load;
  logic          div_busy, div_done;
  logic [W-1:0]  div_quo;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pend_d    = pend_q;
    accept    = 1'b0;
    div_start = 1'b0;
    timeout   = (state_q != IDLE) && (cnt_q == MAX_IVL);
    if (timeout) begin
      // A beat coinciding with the timeout starts a fresh track.
      state_d = beat_pulse ? TRACK : IDLE;
      cnt_d   = beat_pulse ? IW'(1) : '0;
      pend_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (beat_pulse) begin
            state_d = TRACK;
            cnt_d   = IW'(1);
          end
        end
        TRACK, DIVIDE: begin
          accept    = beat_pulse && (cnt_q >= MIN_IVL);
          cnt_d     = accept ? IW'(1) : cnt_q + IW'(1);
          div_start = (wr2_q || pend_q) && !div_busy;
          if (wr2_q && div_busy)
            pend_d = 1'b1;
          else if (div_start)
            pend_d = 1'b0;
          if (state_q == TRACK && div_start)
            state_d = DIVIDE;
          else if (state_q == DIVIDE && div_done && !div_start)
            state_d = TRACK;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign out_load = (state_q == DIVIDE) && div_done && !timeout;

  always_comb begin
    sum_c = '0;
    for (int i = 0; i < RING_DEPTH; i++)
      sum_c = sum_c + SW'(ring_q[i]);
  end

  // The counter restarts at 1 so that it reads the cycles elapsed since the last accepted beat.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      for (int i = 0; i < RING_DEPTH; i++)
        ring_q[i] <= '0;
      wp_q     <= '0;
      filled_q <= 1'b0;
      sum_q    <= '0;
      wr1_q    <= 1'b0;
      wr2_q    <= 1'b0;
      pend_q   <= 1'b0;
      bpm_q    <= '0;
      valid_q  <= 1'b0;
      upd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      sum_q   <= sum_c;
      wr1_q   <= accept;
      wr2_q   <= wr1_q && !timeout;
      upd_q   <= 1'b0;
      if (timeout) begin
        for (int i = 0; i < RING_DEPTH; i++)
          ring_q[i] <= '0;
        wp_q     <= '0;
        filled_q <= 1'b0;
        bpm_q    <= '0;
        valid_q  <= 1'b0;
        upd_q    <= 1'b1;
      end else begin
        if (accept) begin
          if (!filled_q) begin
            for (int i = 0; i < RING_DEPTH; i++)
              ring_q[i] <= cnt_q;
            filled_q <= 1'b1;
          end else begin
            ring_q[wp_q] <= cnt_q;
            wp_q         <= wp_q + PW'(1);
          end
        end
        if (out_load) begin
          bpm_q   <= (div_quo > SAT_W) ? SAT_B : div_quo[BW-1:0];
          valid_q <= 1'b1;
          upd_q   <= 1'b1;
        end
      end
    end
  end

  seq_divider #(.W(W)) u_div (
    .clk      (clk),
    .reset    (reset),
    .start    (div_start),
    .abort    (timeout),
    .dividend (DVD),
    .divisor  (W'(sum_q >> 2)),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (div_quo)
  );

  assign BPM_estimate = bpm_q;
  assign bpm_valid    = valid_q;
  assign bpm_update   = upd_q;

endmodule

// File: doc/bpm_estimator.md
BPM_ESTIMATOR -- requirements
Module: bpm_estimator

Interface
REQ-001 SHALL have parameter CLK_FREQ_HZ, default 50_000_000, meaning clk frequency in Hz.
REQ-002 SHALL have parameter MAX_BPM, default 200, meaning the highest tempo accepted and the output saturation value.
REQ-003 SHALL have parameter MIN_BPM, default 40, meaning the lowest tempo tracked before timeout.
REQ-004 SHALL have port clk, input, 1, the single clock; all logic SHALL be on its rising edge.
REQ-005 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port beat_pulse, input, 1, a single-cycle beat strobe synchronous to clk.
REQ-007 SHALL have port BPM_estimate, output, $clog2(MAX_BPM+1), the current tempo, which feeds brightness_filter directly.
REQ-008 SHALL have port bpm_valid, output, 1, high while BPM_estimate reflects a tracked tempo.
REQ-009 SHALL have port bpm_update, output, 1, a one-cycle pulse in the cycle BPM_estimate changes value source.

Function
REQ-010 SHALL derive the constants MIN_INTERVAL = 60*CLK_FREQ_HZ/MAX_BPM and MAX_INTERVAL = 60*CLK_FREQ_HZ/MIN_BPM in cycles, and DIVIDEND = 60*CLK_FREQ_HZ; each SHALL be sized with $clog2.
REQ-011 SHALL run an interval counter that increments every cycle in TRACK/DIVIDE and saturates at MAX_INTERVAL.
REQ-012 SHALL implement states IDLE (no prior beat), TRACK (counting since the last accepted beat) and DIVIDE (divider busy, counter still running).
REQ-013 In IDLE, beat_pulse SHALL clear the counter and move the block to TRACK; no interval is recorded.
REQ-014 In TRACK/DIVIDE, a beat with counter < MIN_INTERVAL SHALL be ignored, with the counter not cleared (debounce).
REQ-015 In TRACK/DIVIDE, a beat with MIN_INTERVAL <= counter < MAX_INTERVAL SHALL write the counter into a 4-entry ring buffer and clear the counter.
REQ-016 The first interval recorded after IDLE SHALL be written into all 4 entries (pre-fill), so the average is always over 4 entries.
REQ-017 The average interval SHALL be the sum of the 4 entries >> 2, with the sum width equal to interval width + 2 and no truncation before the shift.
REQ-018 The quotient DIVIDE = DIVIDEND / avg_interval SHALL be computed by a restoring sequential divider at 1 quotient bit per cycle, truncated toward zero.
REQ-019 BPM_estimate SHALL be min(quotient, MAX_BPM).
REQ-020 Timing SHALL be as follows, counting the accepted beat cycle as cycle 0:
- ring write at the end of cycle 0;
- sum registered in cycle 1;
- divider started in cycle 2;
- BPM_estimate/bpm_update/bpm_valid updated in cycle 2+W+1, where W = the dividend width.
REQ-021 An accepted beat during DIVIDE SHALL be written to the ring and set a pending flag; at divide completion the output SHALL still be updated, and a new divide SHALL start immediately from the new sum.
REQ-022 When the counter reaches MAX_INTERVAL, the block SHALL return to IDLE:
- clear ring and pending;
- set BPM_estimate=0 and bpm_valid=0;
- pulse bpm_update once.
An in-flight divide SHALL be aborted and its result discarded.
REQ-023 A beat in the same cycle as the timeout SHALL be treated as an IDLE first beat.
REQ-024 BPM_estimate SHALL hold its value between updates and never glitch mid-divide.

Reset
REQ-025 Asserting reset SHALL immediately force IDLE, counter=0, ring=0, pending=0, BPM_estimate=0, bpm_valid=0 and bpm_update=0.
REQ-026 Reset asserted mid-divide SHALL abort the divide; after release, the block SHALL wait in IDLE for a beat.
REQ-027 Reset SHALL be released synchronously by the instantiating top; the block SHALL require no extra cycles after release.

Structure
REQ-028 A shared package bpm_pkg SHALL hold the state enum (IDLE, TRACK, DIVIDE), the ring depth constant (4) and the interval/dividend width functions.
REQ-029 The divider SHALL be a sub-module seq_divider with the following interface:
- ports start, dividend, divisor, busy, done, quotient;
- parameterised width;
- same clk and reset;
- abort input.
REQ-030 The top block SHALL own the FSM, counter, ring buffer and output registers.

Verification (CLK_FREQ_HZ=1000, MAX_BPM=200, MIN_BPM=40: MIN_INTERVAL=300, MAX_INTERVAL=1500, DIVIDEND=60000)
REQ-031 Beats every 500 cycles × 3 -> after the 2nd beat, BPM_estimate=120, bpm_valid=1 and bpm_update pulses exactly once per accepted beat at the spec'd latency.
REQ-032 Steady beats at 500 then intervals 400,400,400,400 -> averages 475, 450, 425, 400 and outputs 126, 133, 141, 150.
REQ-033 Beats at 500 plus an extra beat 100 cycles after one beat -> extra ignored, and the next interval is measured from the original beat (still 120).
REQ-034 Beats stop after lock -> at 1500 cycles, BPM_estimate=0, bpm_valid=0, one bpm_update pulse; the next beat yields no output until one further beat.
REQ-035 Beat pair at interval 300 -> quotient 200 = MAX_BPM is output; interval 1499 -> 40.
REQ-036 Reset asserted 10 cycles into a divide -> all outputs 0 immediately, and no bpm_update occurs after release without two new beats.
